// File: rtl/conv_pkg.sv
// +--------------------------------------------------------------------+
// | conv_pkg: shared types and helpers for the BCD/binary converters.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // ceil(log2(10**n)); valid for n up to 38 digits.
  function automatic int bcd_bin_width(input int n);
    logic [127:0] p;
    int w;
    p = 128'd1;
    for (int i = 0; i < n; i++) p = p * 128'd10;
    w = 0;
    for (int i = 0; i < 128; i++) begin
      if ((128'd1 << i) < p) w = i + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_mac_x10.sv
// +--------------------------------------------------------------------+
// | bcd_mac_x10: combinational acc*10 + digit with range/digit flags.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module bcd_mac_x10
  import conv_pkg::*;
#(
  parameter int accWidth    = 14,
  parameter int resultWidth = 10
) (
  input  logic [accWidth-1:0] acc,
  input  logic [3:0]          digit,
  output logic [accWidth-1:0] accNext,
  output logic                overflowOut,
  output logic                digitInvalid
);

  logic [accWidth+3:0] product;

  always_comb begin
    product      = ({4'd0, acc} << 3) + ({4'd0, acc} << 1) + {{accWidth{1'b0}}, digit};
    accNext      = product[accWidth-1:0];
    // Flag anything that no longer fits in the result width, including carry past the accumulator.
    overflowOut  = |product[accWidth+3:resultWidth];
    digitInvalid = (digit > BCD_MAX);
  end

endmodule

`default_nettype wire

// File: rtl/decimal_to_binary_seq.sv
// +--------------------------------------------------------------------+
// | decimal_to_binary_seq: sequential BCD-to-binary (Horner, MSD 1st). |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module decimal_to_binary_seq
  import conv_pkg::*;
#(
  parameter int numberOfDigits    = 3,
  parameter int binaryNumberWidth = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [numberOfDigits-1:0][3:0]     BinaryDecimal,
  output logic [binaryNumberWidth-1:0]       binaryNumber,
  output logic                               enaOut,
  output logic                               busy,
  output logic                               digitError,
  output logic                               overflow
);

  localparam int accWidth  = binaryNumberWidth + 4;
  localparam int cntWidth  = (numberOfDigits > 1) ? $clog2(numberOfDigits) : 1;
  localparam int minWidth  = bcd_bin_width(numberOfDigits);
  localparam bit fullRange = (binaryNumberWidth >= minWidth);

  generate
    if (!fullRange) begin : g_narrowRange
      // Narrow result: large inputs are reported through the overflow flag.
    end
  endgenerate

  conv_state_t                        state;
  conv_state_t                        nextState;
  logic [numberOfDigits-1:0][3:0]     digitReg;
  logic [cntWidth-1:0]                cnt;
  logic [accWidth-1:0]                acc;
  logic                               errSticky;
  logic                               ovfSticky;
  logic [accWidth-1:0]                macAcc;
  logic                               macOverflow;
  logic                               macInvalid;

  bcd_mac_x10 #(
    .accWidth    (accWidth),
    .resultWidth (binaryNumberWidth)
  ) u_mac (
    .acc          (acc),
    .digit        (digitReg[cnt]),
    .accNext      (macAcc),
    .overflowOut  (macOverflow),
    .digitInvalid (macInvalid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (load) begin
      nextState = RUN;
    end else begin
      case (state)
        IDLE:    nextState = IDLE;
        RUN:     if (cnt == '0) nextState = DONE;
        DONE:    nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digitReg     <= '0;
      cnt          <= '0;
      acc          <= '0;
      errSticky    <= 1'b0;
      ovfSticky    <= 1'b0;
      binaryNumber <= '0;
      enaOut       <= 1'b0;
      digitError   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      enaOut <= 1'b0;
      // A load wins over RUN/DONE, so an aborted conversion never publishes.
      if (load) begin
        digitReg  <= BinaryDecimal;
        acc       <= '0;
        errSticky <= 1'b0;
        ovfSticky <= 1'b0;
        cnt       <= cntWidth'(numberOfDigits - 1);
      end else if (state == RUN) begin
        acc       <= macAcc;
        errSticky <= errSticky | macInvalid;
        ovfSticky <= ovfSticky | macOverflow;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end else if (state == DONE) begin
        binaryNumber <= (errSticky || ovfSticky) ? '0 : acc[binaryNumberWidth-1:0];
        enaOut       <= 1'b1;
        digitError   <= errSticky;
        overflow     <= ovfSticky;
      end
    end
  end

endmodule

`default_nettype wire
